// File: rtl/mrx_tag_chip_pkg.sv
// Shared types and helpers for the tag-chip RX sequencer.
// Holds the state encoding, saturating magnitude and default constants.
package mrx_tag_chip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_SYNC = 2'b01,
        ST_SYNC      = 2'b10,
        ST_HOP_RX    = 2'b11
    } rx_state_e;

    localparam int          DEF_SYNC_IN_BIT  = 1;
    localparam logic [15:0] DEF_QUIET_THRESH = 16'd256;

    // Magnitude of a sign-extended w-bit value; the most negative
    // code folds onto the largest positive one.
    function automatic logic [31:0] sat_abs(
        input logic signed [31:0] x,
        input int                 w
    );
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (w - 1)) - 32'd1;
        mag = x[31] ? 32'(-x) : 32'(x);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for GPIO bits.
// Ports: clk, reset (sync, high), d_i async inputs, rise_o 1-clk edge pulses.
module gpio_in_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/mrx_ctrl_tag_chip_nb.sv
// RX sequencer: locks to the GPIO sync strobe, checks the quiet gap,
// frames hops into symbols and steps the per-hop NCO increment.
// Ports: irx/qrx/in_tvalid in; itx_out/qtx_out/out_tvalid/sym_last/
// hop_last sample out; hop_ph_inc/nhop/symbN/rx_state status;
// quiet_err/resync 1-clk pulses; fp_gpio_in async strobe inputs.
module mrx_ctrl_tag_chip_nb
    import mrx_tag_chip_pkg::*;
#(
    parameter int                      DATA_WIDTH     = 16,
    parameter int                      PHASE_WIDTH    = 24,
    parameter int                      NSYMB_WIDTH    = 16,
    parameter int                      NHOP_WIDTH     = 8,
    parameter int                      GPIO_REG_WIDTH = 12,
    parameter int                      NUM_HOPS       = 64,
    parameter int                      NSYMB_PER_HOP  = 8,
    parameter int                      NSIG           = 16384,
    parameter logic [PHASE_WIDTH-1:0]  START_PH_INC   = -24'd4194304,
    parameter logic [PHASE_WIDTH-1:0]  HOP_DPH_INC    = PHASE_WIDTH'(131072),
    parameter int                      SYNC_IN_BIT    = DEF_SYNC_IN_BIT,
    parameter logic [DATA_WIDTH-1:0]   QUIET_THRESH   = DATA_WIDTH'(DEF_QUIET_THRESH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     irx,
    input  logic [DATA_WIDTH-1:0]     qrx,
    input  logic                      in_tvalid,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [DATA_WIDTH-1:0]     itx_out,
    output logic [DATA_WIDTH-1:0]     qtx_out,
    output logic                      out_tvalid,
    output logic                      sym_last,
    output logic                      hop_last,
    output logic [PHASE_WIDTH-1:0]    hop_ph_inc,
    output logic [NHOP_WIDTH-1:0]     nhop,
    output logic [NSYMB_WIDTH-1:0]    symbN,
    output logic [1:0]                rx_state,
    output logic                      quiet_err,
    output logic                      resync
);

    localparam int CNT_W = $clog2(NSIG);
    localparam logic [CNT_W-1:0]       LAST_SAMP = CNT_W'(NSIG - 1);
    localparam logic [CNT_W-1:0]       QUIET_END = CNT_W'(NSIG / 4);
    localparam logic [NSYMB_WIDTH-1:0] LAST_SYM  = NSYMB_WIDTH'(NSYMB_PER_HOP - 1);
    localparam logic [NHOP_WIDTH-1:0]  LAST_HOP  = NHOP_WIDTH'(NUM_HOPS - 1);

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        samp_q, samp_d;
    logic [NSYMB_WIDTH-1:0]  symb_q, symb_d;
    logic [NHOP_WIDTH-1:0]   nhop_q, nhop_d;
    logic [PHASE_WIDTH-1:0]  ph_q, ph_d;
    logic                    qfail_q, qfail_d;
    logic [DATA_WIDTH-1:0]   itx_q, itx_d, qtx_q, qtx_d;
    logic                    tvalid_q, tvalid_d;
    logic                    sym_last_q, sym_last_d;
    logic                    hop_last_q, hop_last_d;
    logic                    qerr_q, qerr_d;
    logic                    resync_q, resync_d;

    logic sync_edge;
    logic gpio_unused;
    logic samp_last;
    logic hop_end;
    logic loud;
    logic qfail_now;

    gpio_in_sync #(
        .WIDTH (1)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (fp_gpio_in[SYNC_IN_BIT]),
        .rise_o (sync_edge)
    );

    assign gpio_unused = ^fp_gpio_in;

    assign samp_last = (samp_q == LAST_SAMP);
    assign hop_end   = in_tvalid && samp_last && (symb_q == LAST_SYM);
    assign loud      = (sat_abs(32'($signed(irx)), DATA_WIDTH) >= 32'(QUIET_THRESH))
                    || (sat_abs(32'($signed(qrx)), DATA_WIDTH) >= 32'(QUIET_THRESH));
    assign qfail_now = qfail_q || ((samp_q < QUIET_END) && loud);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            samp_q     <= '0;
            symb_q     <= '0;
            nhop_q     <= '0;
            ph_q       <= START_PH_INC;
            qfail_q    <= 1'b0;
            itx_q      <= '0;
            qtx_q      <= '0;
            tvalid_q   <= 1'b0;
            sym_last_q <= 1'b0;
            hop_last_q <= 1'b0;
            qerr_q     <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            symb_q     <= symb_d;
            nhop_q     <= nhop_d;
            ph_q       <= ph_d;
            qfail_q    <= qfail_d;
            itx_q      <= itx_d;
            qtx_q      <= qtx_d;
            tvalid_q   <= tvalid_d;
            sym_last_q <= sym_last_d;
            hop_last_q <= hop_last_d;
            qerr_q     <= qerr_d;
            resync_q   <= resync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        symb_d     = symb_q;
        nhop_d     = nhop_q;
        ph_d       = ph_q;
        qfail_d    = qfail_q;
        itx_d      = irx;
        qtx_d      = qrx;
        tvalid_d   = in_tvalid && (state_q == ST_HOP_RX);
        sym_last_d = 1'b0;
        hop_last_d = 1'b0;
        qerr_d     = 1'b0;
        resync_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_WAIT_SYNC;
            ST_WAIT_SYNC: begin
                if (sync_edge) begin
                    state_d = ST_SYNC;
                    samp_d  = '0;
                    qfail_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (in_tvalid) begin
                    if (samp_last) begin
                        samp_d = '0;
                        if (qfail_now) begin
                            qerr_d  = 1'b1;
                            state_d = ST_WAIT_SYNC;
                        end else begin
                            symb_d  = '0;
                            state_d = ST_HOP_RX;
                        end
                    end else begin
                        samp_d  = samp_q + CNT_W'(1);
                        qfail_d = qfail_now;
                    end
                end
            end
            ST_HOP_RX: begin
                sym_last_d = in_tvalid && samp_last;
                hop_last_d = hop_end;
                if (hop_end) begin
                    // A strobe landing on the hop end starts the next sync.
                    if (nhop_q == LAST_HOP) begin
                        nhop_d = '0;
                        ph_d   = START_PH_INC;
                    end else begin
                        nhop_d = nhop_q + NHOP_WIDTH'(1);
                        ph_d   = ph_q + HOP_DPH_INC;
                    end
                    samp_d  = '0;
                    symb_d  = '0;
                    qfail_d = 1'b0;
                    state_d = sync_edge ? ST_SYNC : ST_WAIT_SYNC;
                end else if (sync_edge) begin
                    resync_d = 1'b1;
                    samp_d   = '0;
                    symb_d   = '0;
                    qfail_d  = 1'b0;
                    state_d  = ST_SYNC;
                end else if (in_tvalid) begin
                    if (samp_last) begin
                        samp_d = '0;
                        symb_d = symb_q + NSYMB_WIDTH'(1);
                    end else begin
                        samp_d = samp_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign itx_out    = itx_q;
    assign qtx_out    = qtx_q;
    assign out_tvalid = tvalid_q;
    assign sym_last   = sym_last_q;
    assign hop_last   = hop_last_q;
    assign hop_ph_inc = ph_q;
    assign nhop       = nhop_q;
    assign symbN      = symb_q;
    assign rx_state   = state_q;
    assign quiet_err  = qerr_q;
    assign resync     = resync_q;

endmodule
